// File: rtl/operand_accum_32.sv
// Burst accumulator behind the 32-bit 4:1 operand mux: adds/subtracts len operands and reports sum, carry and sticky overflow.
// Optional build macro OPERAND_ACCUM_SATURATE_EN clamps the running sum on signed overflow instead of wrapping.
module operand_accum_32 #(
  parameter int WIDTH   = 32,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [COUNT_W-1:0] i_len,
  input  logic               i_sub,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WIDTH-1:0]   i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [WIDTH-1:0]   o_sum,
  output logic               o_carry,
  output logic               o_overflow,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};

  state_t               r_state;
  state_t               w_next_state;
  logic [WIDTH-1:0]     r_acc;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_carry;
  logic                 r_overflow;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;

  logic                 w_beat;
  logic                 w_start_ok;
  logic [WIDTH-1:0]     w_operand;
  logic [WIDTH:0]       w_raw;
  logic                 w_ovf_beat;
  logic [WIDTH-1:0]     w_acc_next;

  assign w_start_ok = (r_state == ST_IDLE) && i_start;
  assign w_beat     = (r_state == ST_ACCUM) && r_in_ready && i_in_valid;

  // Subtraction is acc + ~in_data + 1; the carry-in supplies the +1.
  assign w_operand  = i_sub ? ~i_in_data : i_in_data;
  assign w_raw      = {1'b0, r_acc} + {1'b0, w_operand} + {{WIDTH{1'b0}}, i_sub};
  assign w_ovf_beat = (r_acc[WIDTH-1] == w_operand[WIDTH-1]) &&
                      (w_raw[WIDTH-1] != r_acc[WIDTH-1]);

  // Next accumulator value: wrap by default, clamp when saturation is built in.
  always_comb begin
    w_acc_next = w_raw[WIDTH-1:0];
`ifdef OPERAND_ACCUM_SATURATE_EN
    if (w_ovf_beat) begin
      w_acc_next = r_acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_acc_next = w_raw[WIDTH-1:0];
    end
`endif
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = (i_len != COUNT_ZERO) ? ST_ACCUM : ST_DONE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_beat && (r_count == COUNT_ONE)) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (r_out_valid && i_out_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_DONE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Handshake and status flags are registered from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == ST_ACCUM);
      r_out_valid <= (w_next_state == ST_DONE);
      r_busy      <= (w_next_state != ST_IDLE);
    end
  end

  // Accumulator, beat counter and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= {WIDTH{1'b0}};
      r_count    <= COUNT_ZERO;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_acc      <= {WIDTH{1'b0}};
      r_count    <= i_len;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_beat) begin
      r_acc      <= w_acc_next;
      r_count    <= r_count - COUNT_ONE;
      r_carry    <= w_raw[WIDTH];
      r_overflow <= r_overflow | w_ovf_beat;
    end else begin
      r_acc      <= r_acc;
      r_count    <= r_count;
      r_carry    <= r_carry;
      r_overflow <= r_overflow;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_sum       = r_acc;
  assign o_carry     = r_carry;
  assign o_overflow  = r_overflow;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_operand_accum_32.sv
// Scoreboard bench for operand_accum_32: expected results are queued per burst and compared on the output handshake.
module tb_operand_accum_32;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [3:0]  i_len;
  logic        i_sub;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_in_data;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_sum;
  logic        o_carry;
  logic        o_overflow;
  logic        o_busy;

  int checks_cnt;
  int fail_cnt;
  exp_t exp_q[$];
  logic [31:0] op_data [16];
  logic        op_sub  [16];

  operand_accum_32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_sub      (i_sub),
    .i_in_valid (i_in_valid),
    .o_in_ready (o_in_ready),
    .i_in_data  (i_in_data),
    .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready),
    .o_sum      (o_sum),
    .o_carry    (o_carry),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.carry = c; e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Reference arithmetic over op_data/op_sub for n beats.
  function automatic exp_t model(input int n);
    exp_t e;
    logic [31:0] acc;
    logic [31:0] op;
    logic [32:0] r;
    logic        ov;
    acc = 32'd0; e.carry = 1'b0; e.ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      op = op_sub[i] ? ~op_data[i] : op_data[i];
      r  = {1'b0, acc} + {1'b0, op} + {32'd0, op_sub[i]};
      ov = (acc[31] == op[31]) && (r[31] != acc[31]);
      e.carry = r[32];
      e.ovf   = e.ovf | ov;
`ifdef OPERAND_ACCUM_SATURATE_EN
      if (ov) acc = acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else    acc = r[31:0];
`else
      acc = r[31:0];
`endif
    end
    e.sum = acc;
    return e;
  endfunction

  // Result monitor: a handshake will occur on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && o_out_valid && i_out_ready) begin
      check_val("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("sum", o_sum, e.sum);
        check_val("carry", 32'(o_carry), 32'(e.carry));
        check_val("overflow", 32'(o_overflow), 32'(e.ovf));
      end
    end
  end

  task automatic check_idle(input string tag);
    check_val({tag, "_in_ready"}, 32'(o_in_ready), 32'd0);
    check_val({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  task automatic start_burst(input logic [3:0] len);
    i_start = 1'b1; i_len = len;
    tick();
    i_start = 1'b0;
    check_val("start_busy", 32'(o_busy), 32'd1);
    check_val("start_in_ready", 32'(o_in_ready), 32'(len != 4'd0));
  endtask

  task automatic feed(input int n, input logic [15:0] pat, input int plen);
    int k;
    int c;
    logic v;
    k = 0; c = 0;
    while (k < n && c < 64) begin
      v = (c < plen) ? pat[c] : 1'b1;
      i_in_valid = v;
      if (v) begin
        i_in_data = op_data[k]; i_sub = op_sub[k]; k++;
      end else begin
        i_in_data = 32'hDEAD_BEEF; i_sub = 1'b1;
      end
      check_val("in_ready_accum", 32'(o_in_ready), 32'd1);
      tick();
      c++;
    end
    i_in_valid = 1'b0;
  endtask

  task automatic collect(input int stall, input exp_t e);
    i_out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      check_val("hold_valid", 32'(o_out_valid), 32'd1);
      check_val("hold_sum", o_sum, e.sum);
      check_val("hold_flags", {30'd0, o_carry, o_overflow}, {30'd0, e.carry, e.ovf});
      i_start = (i == 2); i_len = 4'd2;
      tick();
    end
    i_start = 1'b1; i_len = 4'd3; i_out_ready = 1'b1;
    tick();
    i_start = 1'b0; i_out_ready = 1'b0;
    check_idle("after_done");
  endtask

  task automatic run_burst(input logic [3:0] len, input logic [15:0] pat, input int plen,
                           input int stall, input exp_t e);
    exp_q.push_back(e);
    start_burst(len);
    if (len != 4'd0) feed(int'(len), pat, plen);
    check_val("out_latency", 32'(o_out_valid), 32'd1);
    check_val("done_in_ready", 32'(o_in_ready), 32'd0);
    check_val("done_busy", 32'(o_busy), 32'd1);
    collect(stall, e);
  endtask

  exp_t ex;

  initial begin
    checks_cnt = 0; fail_cnt = 0;
    rst_n = 1'b0; i_start = 1'b0; i_len = 4'd0; i_sub = 1'b0;
    i_in_valid = 1'b0; i_in_data = 32'd0; i_out_ready = 1'b0;
    #1;
    check_idle("reset");
    check_val("reset_sum", o_sum, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Abort a burst after two beats.
    op_data[0] = 32'd9; op_sub[0] = 1'b0;
    op_data[1] = 32'd4; op_sub[1] = 1'b0;
    start_burst(4'd3);
    feed(2, 16'hFFFF, 16);
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    check_val("midreset_sum", o_sum, 32'd0);
    check_val("midreset_flags", {30'd0, o_carry, o_overflow}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Basic add 1+2+3.
    op_data[0] = 32'd1; op_data[1] = 32'd2; op_data[2] = 32'd3;
    op_sub[0] = 1'b0; op_sub[1] = 1'b0; op_sub[2] = 1'b0;
    ex.sum = 32'd6; ex.carry = 1'b0; ex.ovf = 1'b0;
    run_burst(4'd3, 16'hFFFF, 16, 0, ex);

    // 5 - 7 with borrow, result held under back-pressure.
    op_data[0] = 32'd5; op_sub[0] = 1'b0;
    op_data[1] = 32'd7; op_sub[1] = 1'b1;
    ex.sum = 32'hFFFF_FFFE; ex.carry = 1'b0; ex.ovf = 1'b0;
    run_burst(4'd2, 16'hFFFF, 16, 5, ex);

    // Signed overflow.
    op_data[0] = 32'h7FFF_FFFF; op_sub[0] = 1'b0;
    op_data[1] = 32'h0000_0001; op_sub[1] = 1'b0;
`ifdef OPERAND_ACCUM_SATURATE_EN
    ex.sum = 32'h7FFF_FFFF;
`else
    ex.sum = 32'h8000_0000;
`endif
    ex.carry = 1'b0; ex.ovf = 1'b1;
    run_burst(4'd2, 16'hFFFF, 16, 1, ex);

    // Input stalls with valid pattern 1,0,0,1,1,0,1.
    op_data[0] = 32'd10; op_data[1] = 32'd20; op_data[2] = 32'd30; op_data[3] = 32'd40;
    for (int i = 0; i < 4; i++) op_sub[i] = 1'b0;
    ex.sum = 32'd100; ex.carry = 1'b0; ex.ovf = 1'b0;
    run_burst(4'd4, 16'b0000_0000_0101_1001, 7, 0, ex);

    // Empty burst.
    ex.sum = 32'd0; ex.carry = 1'b0; ex.ovf = 1'b0;
    run_burst(4'd0, 16'hFFFF, 16, 0, ex);

    // Maximum length of all-ones operands.
    for (int i = 0; i < 15; i++) begin
      op_data[i] = 32'hFFFF_FFFF; op_sub[i] = 1'b0;
    end
    ex.sum = 32'hFFFF_FFF1; ex.carry = 1'b1; ex.ovf = 1'b0;
    run_burst(4'd15, 16'hFFFF, 16, 0, ex);

    // Random bursts against the reference model.
    for (int t = 0; t < 4; t++) begin
      logic [3:0] l;
      l = 4'($urandom_range(1, 15));
      for (int i = 0; i < 16; i++) begin
        op_data[i] = (t == 0) ? 32'h4000_0000 + $urandom_range(0, 255) : $urandom;
        op_sub[i]  = 1'($urandom_range(0, 1));
      end
      ex = model(int'(l));
      run_burst(l, 16'($urandom), 16, $urandom_range(0, 3), ex);
    end

    tick(); tick();
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
